// File: rtl/binary_centroid_pkg.sv
// Shared defaults, derived widths and FSM state type for the binary centroid block.
// Derived widths here describe the default build; modules re-derive from their own parameters.
package centroid_pkg;

  localparam int DEF_IMG_W  = 320;
  localparam int DEF_IMG_H  = 240;
  localparam int DEF_ADDR_W = 17;
  localparam int DEF_X_W    = $clog2(DEF_IMG_W);
  localparam int DEF_Y_W    = $clog2(DEF_IMG_H);
  localparam int DEF_SUM_W  = DEF_ADDR_W + DEF_X_W;

  typedef enum logic [1:0] {
    IDLE,
    DIVIDE,
    DONE
  } state_t;

endpackage

// File: rtl/binary_centroid_if.sv
// Capture-stage pixel write stream plus the centroid result bundle.
// master = capture/steering side, slave = binary_centroid.
interface binary_centroid_if
  import centroid_pkg::*;
#(
  parameter int IMG_W  = DEF_IMG_W,
  parameter int IMG_H  = DEF_IMG_H,
  parameter int ADDR_W = DEF_ADDR_W
);
  localparam int X_W = $clog2(IMG_W);
  localparam int Y_W = $clog2(IMG_H);

  logic [ADDR_W-1:0] wr_addr;
  logic              wr_data;
  logic              wr_en;
  logic              frame_done;
  logic [ADDR_W-1:0] min_count;
  logic [X_W-1:0]    cent_x;
  logic [Y_W-1:0]    cent_y;
  logic [ADDR_W-1:0] pix_count;
  logic              found;
  logic              result_valid;
  logic              busy;
  logic              addr_err;
  logic              overrun;

  modport master (
    output wr_addr, wr_data, wr_en, frame_done, min_count,
    input  cent_x, cent_y, pix_count, found, result_valid, busy, addr_err, overrun
  );

  modport slave (
    input  wr_addr, wr_data, wr_en, frame_done, min_count,
    output cent_x, cent_y, pix_count, found, result_valid, busy, addr_err, overrun
  );

endinterface

// File: rtl/binary_centroid_seq_divider.sv
// Restoring unsigned divider, one quotient bit per clock; start loads operands and does bit one.
// done pulses the cycle after the last of N_W bits; a new start restarts it at any time.
module seq_divider #(
  parameter int N_W = 26,
  parameter int D_W = 17,
  parameter int Q_W = 9
) (
  input  logic           cam_pclk,
  input  logic           reset,
  input  logic           start,
  input  logic [N_W-1:0] dividend,
  input  logic [D_W-1:0] divisor,
  output logic [Q_W-1:0] quotient,
  output logic           done
);
  localparam int C_W = $clog2(N_W + 1);

  logic [D_W-1:0] rem_q, rem_in, rem_d, dvs_q, dvs_in;
  logic [N_W-1:0] quo_q, quo_in;
  logic [D_W:0]   trial;
  logic [C_W-1:0] cnt_q;
  logic           qbit;
  logic           step;

  assign step     = start || (cnt_q != '0);
  assign quotient = quo_q[Q_W-1:0];

  // quo doubles as the dividend shift register: its msb feeds the trial, quotient bits enter at the lsb
  always_comb begin
    rem_in = start ? '0 : rem_q;
    quo_in = start ? dividend : quo_q;
    dvs_in = start ? divisor : dvs_q;
    trial  = {rem_in, quo_in[N_W-1]};
    rem_d  = trial[D_W-1:0];
    qbit   = 1'b0;
    if (trial >= {1'b0, dvs_in}) begin
      rem_d = D_W'(trial - {1'b0, dvs_in});
      qbit  = 1'b1;
    end
  end

  always_ff @(posedge cam_pclk) begin
    if (reset) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (step) begin
        rem_q <= rem_d;
        quo_q <= {quo_in[N_W-2:0], qbit};
        dvs_q <= dvs_in;
        cnt_q <= start ? C_W'(N_W - 1) : cnt_q - 1'b1;
        done  <= !start && (cnt_q == C_W'(1));
      end
    end
  end

endmodule

// File: rtl/binary_centroid.sv
// Accumulates foreground pixel count/coordinate sums per frame and reports the blob centroid.
// Define CENTROID_ROUND_EN for round-half-up centroids; default build truncates.
module binary_centroid
  import centroid_pkg::*;
#(
  parameter int IMG_W  = DEF_IMG_W,
  parameter int IMG_H  = DEF_IMG_H,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic             cam_pclk,
  input  logic             reset,
  binary_centroid_if.slave bus
);
  localparam int X_W   = $clog2(IMG_W);
  localparam int Y_W   = $clog2(IMG_H);
  localparam int SUM_W = ADDR_W + X_W;
  localparam logic [X_W-1:0] X_LAST = X_W'(IMG_W - 1);
  localparam logic [Y_W:0]   Y_END  = (Y_W + 1)'(IMG_H);

  // y needs one spare bit so it can sit at IMG_H once the frame is full
  logic [X_W-1:0]    x_q;
  logic [Y_W:0]      y_q;
  logic [ADDR_W-1:0] exp_addr_q, count_q, count_tot, snap_count_q;
  logic [SUM_W-1:0]  sum_x_q, sum_y_q, sum_x_tot, sum_y_tot, dvd_x, dvd_y;
  logic [X_W-1:0]    quo_x, cent_x_q;
  logic [Y_W-1:0]    quo_y, cent_y_q;
  logic [ADDR_W-1:0] pix_count_q;
  logic in_range, take, busy_i, fd_accept, go, div_start, div_done_x, div_done_y;
  logic snap_pend_q, snap_go_q, found_q, result_valid_q, addr_err_q, overrun_q;
  state_t state_q, state_d;

  assign in_range  = (y_q < Y_END);
  assign take      = bus.wr_en && in_range && bus.wr_data;
  assign count_tot = count_q + ADDR_W'(take);
  assign sum_x_tot = sum_x_q + (take ? SUM_W'(x_q) : '0);
  assign sum_y_tot = sum_y_q + (take ? SUM_W'(y_q) : '0);
  assign busy_i    = snap_pend_q || (state_q != IDLE);
  assign fd_accept = bus.frame_done && !busy_i;
  assign go        = (count_tot >= bus.min_count) && (count_tot != '0);
  assign div_start = fd_accept && go;

`ifdef CENTROID_ROUND_EN
  // sum + count/2 stays below count*IMG_W, so the rounded dividend still fits SUM_W bits
  assign dvd_x = sum_x_tot + SUM_W'(count_tot >> 1);
  assign dvd_y = sum_y_tot + SUM_W'(count_tot >> 1);
`else
  assign dvd_x = sum_x_tot;
  assign dvd_y = sum_y_tot;
`endif

  always_ff @(posedge cam_pclk) begin
    if (reset) begin
      x_q        <= '0;
      y_q        <= '0;
      exp_addr_q <= '0;
      count_q    <= '0;
      sum_x_q    <= '0;
      sum_y_q    <= '0;
      addr_err_q <= 1'b0;
    end else begin
      if (bus.wr_en && (!in_range || (bus.wr_addr != exp_addr_q))) addr_err_q <= 1'b1;
      if (bus.frame_done) begin
        x_q        <= '0;
        y_q        <= '0;
        exp_addr_q <= '0;
        count_q    <= '0;
        sum_x_q    <= '0;
        sum_y_q    <= '0;
      end else if (bus.wr_en && in_range) begin
        count_q    <= count_tot;
        sum_x_q    <= sum_x_tot;
        sum_y_q    <= sum_y_tot;
        x_q        <= (x_q == X_LAST) ? '0 : x_q + 1'b1;
        y_q        <= (x_q == X_LAST) ? y_q + 1'b1 : y_q;
        exp_addr_q <= exp_addr_q + 1'b1;
      end
    end
  end

  seq_divider #(.N_W(SUM_W), .D_W(ADDR_W), .Q_W(X_W)) u_div_x (
    .cam_pclk(cam_pclk), .reset(reset), .start(div_start),
    .dividend(dvd_x), .divisor(count_tot), .quotient(quo_x), .done(div_done_x)
  );

  seq_divider #(.N_W(SUM_W), .D_W(ADDR_W), .Q_W(Y_W)) u_div_y (
    .cam_pclk(cam_pclk), .reset(reset), .start(div_start),
    .dividend(dvd_y), .divisor(count_tot), .quotient(quo_y), .done(div_done_y)
  );

  always_ff @(posedge cam_pclk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // the divide/skip decision is taken one cycle after frame_done from the snapshot
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (snap_pend_q) state_d = snap_go_q ? DIVIDE : DONE;
      DIVIDE:  if (div_done_x && div_done_y) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge cam_pclk) begin
    if (reset) begin
      snap_pend_q    <= 1'b0;
      snap_go_q      <= 1'b0;
      snap_count_q   <= '0;
      overrun_q      <= 1'b0;
      result_valid_q <= 1'b0;
      cent_x_q       <= '0;
      cent_y_q       <= '0;
      pix_count_q    <= '0;
      found_q        <= 1'b0;
    end else begin
      snap_pend_q    <= fd_accept;
      result_valid_q <= (state_q == DONE);
      if (fd_accept) begin
        snap_go_q    <= go;
        snap_count_q <= count_tot;
      end
      if (bus.frame_done && busy_i) overrun_q <= 1'b1;
      if (state_q == DONE) begin
        cent_x_q    <= snap_go_q ? quo_x : '0;
        cent_y_q    <= snap_go_q ? quo_y : '0;
        pix_count_q <= snap_count_q;
        found_q     <= snap_go_q;
      end
    end
  end

  assign bus.cent_x       = cent_x_q;
  assign bus.cent_y       = cent_y_q;
  assign bus.pix_count    = pix_count_q;
  assign bus.found        = found_q;
  assign bus.result_valid = result_valid_q;
  assign bus.busy         = busy_i;
  assign bus.addr_err     = addr_err_q;
  assign bus.overrun      = overrun_q;

endmodule
